// File: rtl/fp_mult_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_mult_pipe_if
// Description : Operand/result handshake bundle for fp_mult_pipe. The slave
//               modport is the multiplier side; master is the producer/consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_mult_pipe_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [1:0]     rnd_mode;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out;
    logic [3:0]     flags;

    modport slave (
        input  in_valid, A, B, rnd_mode, out_ready,
        output in_ready, out_valid, out, flags
    );

    modport master (
        output in_valid, A, B, rnd_mode, out_ready,
        input  in_ready, out_valid, out, flags
    );
endinterface
`default_nettype wire

// File: rtl/fp_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_mult_pipe
// Description : Pipelined IEEE-754 binary multiplier (fp16 by default) with a
//               valid/ready handshake, 2..4 stage latency, four rounding modes
//               and invalid/overflow/underflow/inexact flags. Subnormals are
//               flushed to signed zero on input and output.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mult_pipe #(
    parameter int EXP_W  = 5,
    parameter int MAN_W  = 10,
    parameter int STAGES = 3    // legal range 2..4
) (
    input  wire          CLK,
    input  wire          RESETn,
    fp_mult_pipe_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 1;        // significand incl. hidden bit
    localparam int PW = 2 * SW;           // raw product width
    localparam int XW = EXP_W + 2;        // signed working exponent

    localparam logic [XW-1:0] c_BIAS = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic [XW-1:0] c_EMAX = XW'((1 << EXP_W) - 1);
    localparam logic [XW-1:0] c_ONE  = XW'(1);
    localparam logic [XW-1:0] c_ZERO = XW'(0);
    localparam logic [1:0]    c_RNE  = 2'd0;
    localparam logic [1:0]    c_RTZ  = 2'd1;
    localparam logic [1:0]    c_RUP  = 2'd2;
    localparam logic [W-1:0]  c_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Special-case result travels alongside the datapath and overrides it at pack.
    typedef struct packed {
        logic           spec;
        logic [W-1:0]   sres;
        logic [3:0]     sflg;
        logic [1:0]     rm;
        logic           sign;
        logic [XW-1:0]  exp;
        logic [PW-1:0]  prod;
    } s0_t;

    typedef struct packed {
        logic           spec;
        logic [W-1:0]   sres;
        logic [3:0]     sflg;
        logic [1:0]     rm;
        logic           sign;
        logic [XW-1:0]  exp;
        logic [SW-1:0]  sig;
        logic           rb;     // first bit below the result LSB
        logic           sb;     // OR of everything below rb
    } nrm_t;

    typedef struct packed {
        logic           spec;
        logic [W-1:0]   sres;
        logic [3:0]     sflg;
        logic [1:0]     rm;
        logic           sign;
        logic [XW-1:0]  exp;
        logic [SW-1:0]  sig;
        logic           inx;
    } rnd_t;

    typedef struct packed {
        logic [W-1:0]   res;
        logic [3:0]     flg;
    } res_t;

    function automatic s0_t f_unpack(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [1:0] rm);
        s0_t                o;
        logic [EXP_W-1:0]   ea, eb;
        logic [MAN_W-1:0]   ma, mb;
        logic               nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, snan_a, snan_b;
        ea     = a[W-2 -: EXP_W];
        eb     = b[W-2 -: EXP_W];
        ma     = a[MAN_W-1:0];
        mb     = b[MAN_W-1:0];
        nan_a  = (&ea) & (|ma);
        nan_b  = (&eb) & (|mb);
        inf_a  = (&ea) & ~(|ma);
        inf_b  = (&eb) & ~(|mb);
        zero_a = ~(|ea);    // subnormals count as zero
        zero_b = ~(|eb);
        snan_a = nan_a & ~ma[MAN_W-1];
        snan_b = nan_b & ~mb[MAN_W-1];
        o      = '0;
        o.rm   = rm;
        o.sign = a[W-1] ^ b[W-1];
        o.exp  = XW'(ea) + XW'(eb) - c_BIAS;
        o.prod = PW'({1'b1, ma}) * PW'({1'b1, mb});
        if (nan_a | nan_b) begin
            o.spec = 1'b1;
            o.sres = c_QNAN;
            o.sflg = {snan_a | snan_b, 3'b000};
        end else if ((inf_a & zero_b) | (zero_a & inf_b)) begin
            o.spec = 1'b1;
            o.sres = c_QNAN;
            o.sflg = 4'b1000;
        end else if (inf_a | inf_b) begin
            o.spec = 1'b1;
            o.sres = {o.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero_a | zero_b) begin
            o.spec = 1'b1;
            o.sres = {o.sign, {(W-1){1'b0}}};
        end
        return o;
    endfunction

    // Product lies in [1,4); bring it to [1,2) and split off round/sticky.
    function automatic nrm_t f_norm(input s0_t i);
        nrm_t o;
        o.spec = i.spec;
        o.sres = i.sres;
        o.sflg = i.sflg;
        o.rm   = i.rm;
        o.sign = i.sign;
        if (i.prod[PW-1]) begin
            o.exp = i.exp + c_ONE;
            o.sig = i.prod[PW-1 -: SW];
            o.rb  = i.prod[PW-SW-1];
            o.sb  = |i.prod[PW-SW-2:0];
        end else begin
            o.exp = i.exp;
            o.sig = i.prod[PW-2 -: SW];
            o.rb  = i.prod[PW-SW-2];
            o.sb  = |i.prod[PW-SW-3:0];
        end
        return o;
    endfunction

    function automatic rnd_t f_round(input nrm_t i);
        rnd_t        o;
        logic        inc;
        logic [SW:0] sum;
        case (i.rm)
            c_RNE:   inc = i.rb & (i.sb | i.sig[0]);
            c_RTZ:   inc = 1'b0;
            c_RUP:   inc = (i.rb | i.sb) & ~i.sign;
            default: inc = (i.rb | i.sb) & i.sign;
        endcase
        sum    = {1'b0, i.sig} + {{SW{1'b0}}, inc};
        o.spec = i.spec;
        o.sres = i.sres;
        o.sflg = i.sflg;
        o.rm   = i.rm;
        o.sign = i.sign;
        o.inx  = i.rb | i.sb;
        if (sum[SW]) begin
            o.exp = i.exp + c_ONE;
            o.sig = {1'b1, {MAN_W{1'b0}}};
        end else begin
            o.exp = i.exp;
            o.sig = sum[SW-1:0];
        end
        return o;
    endfunction

    function automatic res_t f_pack(input rnd_t i);
        res_t         o;
        logic [W-1:0] maxf, inf;
        maxf = {i.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        inf  = {i.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        if (i.spec) begin
            o.res = i.sres;
            o.flg = i.sflg;
        end else if ($signed(i.exp) >= $signed(c_EMAX)) begin
            o.flg = 4'b0101;
            case (i.rm)
                c_RNE:   o.res = inf;
                c_RTZ:   o.res = maxf;
                c_RUP:   o.res = i.sign ? maxf : inf;
                default: o.res = i.sign ? inf : maxf;
            endcase
        end else if ($signed(i.exp) <= $signed(c_ZERO)) begin
            o.res = {i.sign, {(W-1){1'b0}}};
            o.flg = 4'b0011;
        end else begin
            o.res = {i.sign, i.exp[EXP_W-1:0], i.sig[MAN_W-1:0]};
            o.flg = {3'b000, i.inx};
        end
        return o;
    endfunction

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] w_acc;     // stage k can take new contents this cycle
    logic              w_in_fire;
    s0_t               r_s0;
    res_t              r_res;

    // Ready chain: a stage accepts if it, or any stage after it, is empty, or the sink is ready.
    always_comb begin : comb_acc
        logic hole;
        hole  = 1'b0;
        w_acc = '0;
        for (int k = 0; k < STAGES; k++) begin
            hole = 1'b0;
            for (int j = k; j < STAGES; j++) begin
                hole = hole | ~r_v[j];
            end
            w_acc[k] = hole | bus.out_ready;
        end
    end

    assign bus.in_ready  = w_acc[0];
    assign w_in_fire     = bus.in_valid & w_acc[0];
    assign bus.out_valid = r_v[STAGES-1];
    assign bus.out       = r_res.res;
    assign bus.flags     = r_res.flg;

    // Stage valid bits shift forward wherever the receiving stage can accept.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_v <= '0;
        end else begin
            if (w_acc[0]) r_v[0] <= bus.in_valid;
            for (int k = 1; k < STAGES; k++) begin
                if (w_acc[k]) r_v[k] <= r_v[k-1];
            end
        end
    end

    // Stage 0: unpack, classify, exponent sum and raw significand product.
    always_ff @(posedge CLK) begin
        if (!RESETn)        r_s0 <= '0;
        else if (w_in_fire) r_s0 <= f_unpack(bus.A, bus.B, bus.rnd_mode);
    end

    if (STAGES == 2) begin : g_st2
        // Final stage: normalise, round and pack in one step.
        always_ff @(posedge CLK) begin
            if (!RESETn)                  r_res <= '0;
            else if (w_acc[1] & r_v[0])   r_res <= f_pack(f_round(f_norm(r_s0)));
        end
    end else if (STAGES == 3) begin : g_st3
        nrm_t r_n;
        // Middle stage: normalise.
        always_ff @(posedge CLK) begin
            if (!RESETn)                  r_n <= '0;
            else if (w_acc[1] & r_v[0])   r_n <= f_norm(r_s0);
        end
        // Final stage: round and pack.
        always_ff @(posedge CLK) begin
            if (!RESETn)                  r_res <= '0;
            else if (w_acc[2] & r_v[1])   r_res <= f_pack(f_round(r_n));
        end
    end else if (STAGES == 4) begin : g_st4
        nrm_t r_n;
        rnd_t r_rd;
        // Middle stage: normalise.
        always_ff @(posedge CLK) begin
            if (!RESETn)                  r_n <= '0;
            else if (w_acc[1] & r_v[0])   r_n <= f_norm(r_s0);
        end
        // Round stage.
        always_ff @(posedge CLK) begin
            if (!RESETn)                  r_rd <= '0;
            else if (w_acc[2] & r_v[1])   r_rd <= f_round(r_n);
        end
        // Final stage: overflow/underflow resolution and pack.
        always_ff @(posedge CLK) begin
            if (!RESETn)                  r_res <= '0;
            else if (w_acc[3] & r_v[2])   r_res <= f_pack(r_rd);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fp_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mult_pipe
// Description : Scoreboard bench for fp_mult_pipe (fp16, 3 stages). Expected
//               results come from a real-arithmetic reference model or from
//               hand-derived constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mult_pipe;
    localparam int EXP_W  = 5;
    localparam int MAN_W  = 10;
    localparam int STAGES = 3;

    logic CLK = 1'b0;
    logic RESETn;

    fp_mult_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_if ();

    fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .STAGES(STAGES)) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (u_if.slave)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    logic [19:0] sb_q[$];      // {flags, out}
    bit          rand_bp = 1'b0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  rm;
        logic [15:0] eo;
        logic [3:0]  ef;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic real p2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) repeat (n) r = r * 2.0;
        else        repeat (-n) r = r / 2.0;
        return r;
    endfunction

    // Reference: exact product in real arithmetic, then rounded to 10 fraction bits.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] rm);
        int  ea, eb, ma, mb, e, ip, be;
        bit  sg, nan_a, nan_b, inf_a, inf_b, z_a, z_b, snan;
        bit  inc;
        real mag, scaled, frac;
        logic [15:0] r;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        ma = int'(a[9:0]);   mb = int'(b[9:0]);
        sg = a[15] ^ b[15];
        nan_a = (ea == 31) && (ma != 0); nan_b = (eb == 31) && (mb != 0);
        inf_a = (ea == 31) && (ma == 0); inf_b = (eb == 31) && (mb == 0);
        z_a = (ea == 0); z_b = (eb == 0);
        snan = (nan_a && ma < 512) || (nan_b && mb < 512);
        if (nan_a || nan_b) return {snan ? 4'b1000 : 4'b0000, 16'h7E00};
        if ((inf_a && z_b) || (z_a && inf_b)) return {4'b1000, 16'h7E00};
        if (inf_a || inf_b) return {4'b0000, sg, 15'h7C00};
        if (z_a || z_b) return {4'b0000, sg, 15'h0000};
        mag = (1024.0 + ma) * p2(ea - 25) * (1024.0 + mb) * p2(eb - 25);
        e = 0;
        while (mag >= p2(e + 1)) e++;
        while (mag < p2(e)) e--;
        scaled = mag * p2(10 - e);
        ip     = $rtoi(scaled);
        frac   = scaled - ip;
        case (rm)
            2'd0:    inc = (frac > 0.5) || (frac == 0.5 && (ip % 2) == 1);
            2'd1:    inc = 1'b0;
            2'd2:    inc = (frac > 0.0) && !sg;
            default: inc = (frac > 0.0) && sg;
        endcase
        if (inc) ip++;
        if (ip == 2048) begin ip = 1024; e++; end
        be = e + 15;
        if (be >= 31) begin
            case (rm)
                2'd0:    r = {sg, 15'h7C00};
                2'd1:    r = {sg, 15'h7BFF};
                2'd2:    r = sg ? 16'hFBFF : 16'h7C00;
                default: r = sg ? 16'hFC00 : 16'h7BFF;
            endcase
            return {4'b0101, r};
        end
        if (be <= 0) return {4'b0011, sg, 15'h0000};
        r = {sg, 5'(be), 10'(ip - 1024)};
        return {3'b000, frac > 0.0, r};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        int          c;
        c = $urandom_range(0, 19);
        v = 16'($urandom);
        case (c)
            0: v[14:0] = 15'h0000;
            1: begin v[14:10] = 5'h00; v[9:0] = 10'($urandom_range(1, 1023)); end
            2: v[14:0] = 15'h7C00;
            3: begin v[14:10] = 5'h1F; v[9] = 1'b1; end
            4: begin v[14:10] = 5'h1F; v[9] = 1'b0; v[8:0] = 9'($urandom_range(1, 511)); end
            default: v[14:10] = 5'($urandom_range(1, 30));
        endcase
        return v;
    endfunction

    // Called just after a rising edge; returns just after the edge that took the operands.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm,
                        input logic [19:0] expv);
        bit got;
        int n;
        got = 1'b0;
        n   = 0;
        u_if.in_valid = 1'b1;
        u_if.A        = a;
        u_if.B        = b;
        u_if.rnd_mode = rm;
        while (!got && n < 200) begin
            @(negedge CLK);
            if (u_if.in_ready) begin
                got = 1'b1;
                sb_q.push_back(expv);
            end
            @(posedge CLK); #1;
            n++;
        end
        u_if.in_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles, required 1");
        end
    endtask

    task automatic send_model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm);
        send(a, b, rm, model(a, b, rm));
    endtask

    task automatic check_latency(input string name);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!u_if.out_valid && n < 20);
        check(name, n, STAGES);
        @(negedge CLK);
        check({name, "_single"}, u_if.out_valid, 1'b0);
        @(posedge CLK); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge CLK); #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer, checks hold under stall.
    initial begin : monitor
        bit          held;
        logic [19:0] hold_val;
        logic [19:0] expv;
        held = 1'b0;
        hold_val = '0;
        forever begin
            @(negedge CLK);
            if (!RESETn) begin
                held = 1'b0;
            end else begin
                if (held) check("stall_hold", {u_if.out_valid, u_if.flags, u_if.out}, {1'b1, hold_val});
                held = 1'b0;
                if (u_if.out_valid) begin
                    if (u_if.out_ready) begin
                        if (sb_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_output: got %h with empty scoreboard, required none",
                                     {u_if.flags, u_if.out});
                        end else begin
                            expv = sb_q.pop_front();
                            check("result", {u_if.flags, u_if.out}, expv);
                        end
                    end else begin
                        held     = 1'b1;
                        hold_val = {u_if.flags, u_if.out};
                    end
                end
            end
        end
    end

    // Random backpressure when enabled.
    initial begin : bp_gen
        forever begin
            @(posedge CLK); #1;
            if (rand_bp) u_if.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t dv[$];
        RESETn         = 1'b0;
        u_if.in_valid  = 1'b0;
        u_if.A         = '0;
        u_if.B         = '0;
        u_if.rnd_mode  = 2'd0;
        u_if.out_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESETn = 1'b1;
        @(negedge CLK);
        check("reset_out_valid", u_if.out_valid, 1'b0);
        check("reset_out", u_if.out, 16'h0000);
        check("reset_flags", u_if.flags, 4'h0);
        check("reset_in_ready", u_if.in_ready, 1'b1);
        @(posedge CLK); #1;

        // Basic product and exact latency.
        u_if.out_ready = 1'b1;
        send(16'h3C00, 16'h3E00, 2'd0, {4'h0, 16'h3E00});
        check_latency("latency");

        // Rounding, overflow and special cases with hand-derived results.
        dv.push_back({16'h3C01, 16'h3C01, 2'd0, 16'h3C02, 4'h1});
        dv.push_back({16'h3C01, 16'h3C01, 2'd1, 16'h3C02, 4'h1});
        dv.push_back({16'h3C01, 16'h3C01, 2'd2, 16'h3C03, 4'h1});
        dv.push_back({16'hBC01, 16'h3C01, 2'd3, 16'hBC03, 4'h1});
        dv.push_back({16'h7BFF, 16'h4000, 2'd0, 16'h7C00, 4'h5});
        dv.push_back({16'h7BFF, 16'h4000, 2'd1, 16'h7BFF, 4'h5});
        dv.push_back({16'hFBFF, 16'h4000, 2'd2, 16'hFBFF, 4'h5});
        dv.push_back({16'hFBFF, 16'h4000, 2'd3, 16'hFC00, 4'h5});
        dv.push_back({16'h0000, 16'h7C00, 2'd0, 16'h7E00, 4'h8});
        dv.push_back({16'h8000, 16'h3C00, 2'd0, 16'h8000, 4'h0});
        dv.push_back({16'h0400, 16'h3800, 2'd0, 16'h0000, 4'h3});
        dv.push_back({16'h7D00, 16'h3C00, 2'd0, 16'h7E00, 4'h8});
        dv.push_back({16'h7E00, 16'h3C00, 2'd0, 16'h7E00, 4'h0});
        dv.push_back({16'h7C00, 16'hC000, 2'd0, 16'hFC00, 4'h0});
        dv.push_back({16'h0001, 16'h3C00, 2'd0, 16'h0000, 4'h0});
        foreach (dv[i]) send(dv[i].a, dv[i].b, dv[i].rm, {dv[i].ef, dv[i].eo});
        drain();

        // Backpressure: 10 operands streamed, sink stalled in cycles 2..8.
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send_model(rand_op(), rand_op(), 2'($urandom_range(0, 3)));
            end
            begin
                u_if.out_ready = 1'b1;
                @(posedge CLK); #1;
                @(posedge CLK); #1;
                u_if.out_ready = 1'b0;
                repeat (6) begin @(posedge CLK); #1; end
                @(negedge CLK);
                check("stall_in_ready", u_if.in_ready, 1'b0);
                check("stall_inflight", sb_q.size(), STAGES);
                @(posedge CLK); #1;
                u_if.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with a full pipeline discards everything.
        u_if.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(16'h3C00 + 16'(i), 16'h4000, 2'd0, 20'h0);
        RESETn = 1'b0;
        sb_q.delete();
        @(posedge CLK); #1;
        RESETn = 1'b1;
        u_if.out_ready = 1'b1;
        @(negedge CLK);
        check("rst_flush_out_valid", u_if.out_valid, 1'b0);
        check("rst_flush_in_ready", u_if.in_ready, 1'b1);
        @(posedge CLK); #1;
        send_model(16'h4200, 16'h4500, 2'd0);
        check_latency("post_reset_latency");

        // Randomised traffic with random gaps and backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin @(posedge CLK); #1; end
            send_model(rand_op(), rand_op(), 2'($urandom_range(0, 3)));
        end
        rand_bp = 1'b0;
        @(posedge CLK); #1;
        u_if.out_ready = 1'b1;
        drain();
        repeat (STAGES + 2) @(posedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
